// File: rtl/sys_rst_sequencer.sv
// Board reset synchronizer and SDRAM power-up / init handshake sequencer.
// Releases downstream logic only once the SDRAM init engine has completed.
module sys_rst_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PWR_CYCLES     = 10000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  output logic       sys_rst_n,
  output logic       init_req,
  output logic       sys_ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_PWR     = 3'd1,
    S_REQ     = 3'd2,
    S_BACKOFF = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BO_LAST  = CNT_W'(15);
  localparam logic [1:0]       RTY_MAX  = 2'(MAX_RETRY);

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             retry_q;
  logic [1:0]             retry_d;
  logic                   init_req_q;
  logic                   sys_ready_q;
  logic                   fault_q;

  // Async assert, sync release: shift ones in once rst_n is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sys_rst_n = sync_q[SYNC_STAGES-1];

  // Retry count after the current attempt fails, saturating at the limit
  assign retry_d = (retry_q == RTY_MAX) ? retry_q : retry_q + 2'd1;

  // Sequencer FSM with registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      retry_q     <= '0;
      init_req_q  <= 1'b0;
      sys_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else if (!sys_rst_n) begin
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      retry_q     <= '0;
      init_req_q  <= 1'b0;
      sys_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_SYNC: begin
          state_q <= S_PWR;
          cnt_q   <= '0;
        end
        S_PWR: begin
          if (cnt_q == PWR_LAST) begin
            state_q    <= S_REQ;
            cnt_q      <= '0;
            init_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_REQ: begin
          if (init_done) begin
            state_q     <= S_RUN;
            init_req_q  <= 1'b0;
            sys_ready_q <= 1'b1;
          end else if (cnt_q == TO_LAST) begin
            cnt_q      <= '0;
            init_req_q <= 1'b0;
            retry_q    <= retry_d;
            if (retry_d == RTY_MAX) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= S_BACKOFF;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BACKOFF: begin
          if (cnt_q == BO_LAST) begin
            state_q    <= S_REQ;
            cnt_q      <= '0;
            init_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_SYNC;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign init_req  = init_req_q;
  assign sys_ready = sys_ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// Bench for sys_rst_sequencer: timeline model of sync, power-up wait,
// request/timeout/backoff attempts, terminal RUN/FAULT and async reset.
module tb_sys_rst_sequencer;

  localparam int PWR  = 1000;
  localparam int TO   = 300;
  localparam int MAXR = 3;
  localparam int BO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done = 1'b0;
  logic       sys_rst_n;
  logic       init_req;
  logic       sys_ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  sys_rst_sequencer #(
    .SYNC_STAGES   (2),
    .PWR_CYCLES    (PWR),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (MAXR),
    .CNT_W         (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_done(init_done),
    .sys_rst_n(sys_rst_n),
    .init_req (init_req),
    .sys_ready(sys_ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  // After release: edges until sys_rst_n, then edges until init_req.
  task automatic wait_seq(input bit noise, output int se, output int pe,
                          output int ps, output int st0);
    se = 0;
    while (sys_rst_n !== 1'b1 && se < 10) begin
      @(posedge clk); #1; se++;
    end
    st0 = int'(state_dbg);
    pe = 0;
    ps = 0;
    while (init_req !== 1'b1 && pe < PWR + 20) begin
      init_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1; pe++;
      if (state_dbg == 3'd1) ps++;
    end
    init_done = 1'b0;
  endtask

  task automatic power_up(input bit noise, output int se, output int pe,
                          output int ps, output int st0);
    init_done = 1'b0;
    rst_n = 1'b0;
    #100;
    rst_n = 1'b1;
    wait_seq(noise, se, pe, ps, st0);
  endtask

  // Drives init_done on REQ cycle done_at[a] of attempt a (-1 = never),
  // measuring init_req-high lengths and the low gaps between attempts.
  task automatic run_attempts(input int done_at[MAXR],
                              output int req_len[MAXR],
                              output int gap_len[MAXR],
                              output int n_att);
    int r;
    bit in_req;
    int budget;
    for (int i = 0; i < MAXR; i++) begin
      req_len[i] = 0;
      gap_len[i] = 0;
    end
    n_att = 0;
    in_req = 1'b0;
    r = 0;
    budget = 0;
    while (budget < MAXR * (TO + BO) + 40) begin
      if (init_req === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1;
          r = 0;
        end
        if (n_att < MAXR) req_len[n_att] = r + 1;
        init_done = (n_att < MAXR) && (done_at[n_att] == r);
        r++;
      end else begin
        if (in_req) begin
          in_req = 1'b0;
          n_att++;
        end
        if (sys_ready === 1'b1 || fault === 1'b1) break;
        if (n_att > 0 && n_att <= MAXR) gap_len[n_att-1]++;
        init_done = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      budget++;
    end
    init_done = 1'b0;
  endtask

  task automatic test_reset;
    #5;
    checks++; if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL rst_sys_rst_n got=%b exp=0", sys_rst_n); end
    checks++; if (init_req !== 1'b0) begin failures++; $display("FAIL rst_init_req got=%b exp=0", init_req); end
    checks++; if (sys_ready !== 1'b0) begin failures++; $display("FAIL rst_sys_ready got=%b exp=0", sys_ready); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", fault); end
    checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL rst_retry got=%0d exp=0", retry_cnt); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (sys_rst_n !== 1'b0 || state_dbg !== 3'd0) begin failures++; $display("FAIL rst_hold got=%b/%0d exp=0/0", sys_rst_n, state_dbg); end
  endtask

  task automatic test_power_on_normal;
    int se, pe, ps, st0, n;
    int d[MAXR], rl[MAXR], gl[MAXR];
    int bad;
    power_up(1'b0, se, pe, ps, st0);
    checks++; if (se !== 2) begin failures++; $display("FAIL por_sync_edges got=%0d exp=2", se); end
    checks++; if (st0 !== 0) begin failures++; $display("FAIL por_state_at_rise got=%0d exp=0", st0); end
    checks++; if (pe !== PWR + 1) begin failures++; $display("FAIL por_req_edges got=%0d exp=%0d", pe, PWR + 1); end
    checks++; if (ps !== PWR) begin failures++; $display("FAIL por_pwr_cycles got=%0d exp=%0d", ps, PWR); end
    d = '{50, -1, -1};
    run_attempts(d, rl, gl, n);
    checks++; if (n !== 1 || rl[0] !== 51) begin failures++; $display("FAIL norm_req got=%0d/%0d exp=1/51", n, rl[0]); end
    checks++; if (sys_ready !== 1'b1 || init_req !== 1'b0) begin failures++; $display("FAIL norm_out got=%b/%b exp=1/0", sys_ready, init_req); end
    checks++; if (retry_cnt !== 2'd0 || state_dbg !== 3'd4) begin failures++; $display("FAIL norm_state got=%0d/%0d exp=0/4", retry_cnt, state_dbg); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL norm_fault got=%b exp=0", fault); end
    bad = 0;
    repeat (40) begin
      init_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (state_dbg !== 3'd4 || sys_ready !== 1'b1 || init_req !== 1'b0) bad++;
    end
    init_done = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL run_hold got=%0d exp=0 bad cycles", bad); end
  endtask

  task automatic test_single_retry;
    int se, pe, ps, st0, n;
    int d[MAXR], rl[MAXR], gl[MAXR];
    power_up(1'b1, se, pe, ps, st0);
    d = '{-1, 10, -1};
    run_attempts(d, rl, gl, n);
    checks++; if (rl[0] !== TO || gl[0] !== BO) begin failures++; $display("FAIL retry_first got=%0d/%0d exp=%0d/%0d", rl[0], gl[0], TO, BO); end
    checks++; if (n !== 2 || rl[1] !== 11) begin failures++; $display("FAIL retry_second got=%0d/%0d exp=2/11", n, rl[1]); end
    checks++; if (retry_cnt !== 2'd1 || state_dbg !== 3'd4 || sys_ready !== 1'b1) begin failures++; $display("FAIL retry_end got=%0d/%0d/%b exp=1/4/1", retry_cnt, state_dbg, sys_ready); end
  endtask

  task automatic test_fault;
    int se, pe, ps, st0, n;
    int d[MAXR], rl[MAXR], gl[MAXR];
    int bad;
    power_up(1'b1, se, pe, ps, st0);
    d = '{-1, -1, -1};
    run_attempts(d, rl, gl, n);
    checks++; if (n !== 3 || rl[0] !== TO || rl[1] !== TO || rl[2] !== TO) begin failures++; $display("FAIL fault_lens got=%0d:%0d/%0d/%0d exp=3:%0d", n, rl[0], rl[1], rl[2], TO); end
    checks++; if (gl[0] !== BO || gl[1] !== BO) begin failures++; $display("FAIL fault_gaps got=%0d/%0d exp=%0d", gl[0], gl[1], BO); end
    checks++; if (fault !== 1'b1 || retry_cnt !== 2'd3 || state_dbg !== 3'd5) begin failures++; $display("FAIL fault_end got=%b/%0d/%0d exp=1/3/5", fault, retry_cnt, state_dbg); end
    bad = 0;
    repeat (60) begin
      init_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (fault !== 1'b1 || sys_ready !== 1'b0 || init_req !== 1'b0 || retry_cnt !== 2'd3) bad++;
    end
    init_done = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL fault_hold got=%0d exp=0 bad cycles", bad); end
  endtask

  task automatic test_simultaneous;
    int se, pe, ps, st0, n;
    int d[MAXR], rl[MAXR], gl[MAXR];
    power_up(1'b0, se, pe, ps, st0);
    d = '{TO - 1, -1, -1};
    run_attempts(d, rl, gl, n);
    checks++; if (n !== 1 || rl[0] !== TO) begin failures++; $display("FAIL simul_req got=%0d/%0d exp=1/%0d", n, rl[0], TO); end
    checks++; if (state_dbg !== 3'd4 || retry_cnt !== 2'd0 || fault !== 1'b0) begin failures++; $display("FAIL simul_end got=%0d/%0d/%b exp=4/0/0", state_dbg, retry_cnt, fault); end
  endtask

  task automatic test_mid_reset;
    int se, pe, ps, st0, n;
    int d[MAXR], rl[MAXR], gl[MAXR];
    power_up(1'b0, se, pe, ps, st0);
    repeat ($urandom_range(1, TO - 10)) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    checks++; if (sys_rst_n !== 1'b0 || init_req !== 1'b0 || state_dbg !== 3'd0) begin failures++; $display("FAIL glitch_req_clr got=%b/%b/%0d exp=0/0/0", sys_rst_n, init_req, state_dbg); end
    #3;
    rst_n = 1'b1;
    wait_seq(1'b1, se, pe, ps, st0);
    checks++; if (se !== 2 || pe !== PWR + 1) begin failures++; $display("FAIL glitch_req_reseq got=%0d/%0d exp=2/%0d", se, pe, PWR + 1); end
    d = '{$urandom_range(0, TO - 1), -1, -1};
    run_attempts(d, rl, gl, n);
    checks++; if (sys_ready !== 1'b1 || rl[0] !== d[0] + 1) begin failures++; $display("FAIL glitch_run_enter got=%b/%0d exp=1/%0d", sys_ready, rl[0], d[0] + 1); end
    rst_n = 1'b0;
    #2;
    checks++; if (sys_rst_n !== 1'b0 || sys_ready !== 1'b0 || state_dbg !== 3'd0) begin failures++; $display("FAIL glitch_run_clr got=%b/%b/%0d exp=0/0/0", sys_rst_n, sys_ready, state_dbg); end
    #3;
    rst_n = 1'b1;
    wait_seq(1'b0, se, pe, ps, st0);
    checks++; if (se !== 2 || pe !== PWR + 1 || ps !== PWR) begin failures++; $display("FAIL glitch_run_reseq got=%0d/%0d/%0d exp=2/%0d/%0d", se, pe, ps, PWR + 1, PWR); end
  endtask

  // Random attempt plans checked against the attempt-level timeline rules
  task automatic test_random;
    int se, pe, ps, st0, n;
    int d[MAXR], rl[MAXR], gl[MAXR];
    int en, er, ef;
    int elen[MAXR];
    bit found;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < MAXR; a++) begin
        case ($urandom_range(0, 3))
          0, 1: d[a] = -1;
          2: d[a] = TO - 1;
          default: d[a] = $urandom_range(0, TO - 1);
        endcase
      end
      found = 1'b0;
      en = MAXR;
      er = MAXR;
      ef = 1;
      for (int a = 0; a < MAXR; a++) begin
        elen[a] = 0;
        if (!found) begin
          if (d[a] >= 0) begin
            found = 1'b1;
            elen[a] = d[a] + 1;
            en = a + 1;
            er = a;
            ef = 0;
          end else begin
            elen[a] = TO;
          end
        end
      end
      power_up(1'b1, se, pe, ps, st0);
      run_attempts(d, rl, gl, n);
      checks++; if (n !== en) begin failures++; $display("FAIL rnd%0d_attempts got=%0d exp=%0d", it, n, en); end
      for (int a = 0; a < en; a++) begin
        checks++; if (rl[a] !== elen[a]) begin failures++; $display("FAIL rnd%0d_len%0d got=%0d exp=%0d", it, a, rl[a], elen[a]); end
        if (a < en - 1) begin
          checks++; if (gl[a] !== BO) begin failures++; $display("FAIL rnd%0d_gap%0d got=%0d exp=%0d", it, a, gl[a], BO); end
        end
      end
      checks++; if (int'(retry_cnt) !== er || int'(fault) !== ef || int'(sys_ready) !== 1 - ef) begin failures++; $display("FAIL rnd%0d_end got=%0d/%b/%b exp=%0d/%0d/%0d", it, retry_cnt, fault, sys_ready, er, ef, 1 - ef); end
      checks++; if (int'(state_dbg) !== (ef ? 5 : 4) || init_req !== 1'b0) begin failures++; $display("FAIL rnd%0d_state got=%0d/%b exp=%0d/0", it, state_dbg, init_req, ef ? 5 : 4); end
    end
  endtask

  initial begin
    test_reset();
    test_power_on_normal();
    test_single_retry();
    test_fault();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
